// File: rtl/seg7_pkg.sv
// Seven-segment glyph constants and the shared glyph-to-nibble decode.
// Pattern bits are g..a (bit6..bit0); anything outside the 16 hex glyphs is bad.
package seg7_pkg;

  localparam int SEG_W = 7;

  localparam logic [SEG_W-1:0] SEG_0 = 7'h3F;
  localparam logic [SEG_W-1:0] SEG_1 = 7'h06;
  localparam logic [SEG_W-1:0] SEG_2 = 7'h5B;
  localparam logic [SEG_W-1:0] SEG_3 = 7'h4F;
  localparam logic [SEG_W-1:0] SEG_4 = 7'h66;
  localparam logic [SEG_W-1:0] SEG_5 = 7'h6D;
  localparam logic [SEG_W-1:0] SEG_6 = 7'h7D;
  localparam logic [SEG_W-1:0] SEG_7 = 7'h07;
  localparam logic [SEG_W-1:0] SEG_8 = 7'h7F;
  localparam logic [SEG_W-1:0] SEG_9 = 7'h6F;
  localparam logic [SEG_W-1:0] SEG_A = 7'h77;
  localparam logic [SEG_W-1:0] SEG_B = 7'h7C;
  localparam logic [SEG_W-1:0] SEG_C = 7'h39;
  localparam logic [SEG_W-1:0] SEG_D = 7'h5E;
  localparam logic [SEG_W-1:0] SEG_E = 7'h79;
  localparam logic [SEG_W-1:0] SEG_F = 7'h71;

  typedef struct packed {
    logic       bad;
    logic [3:0] value;
  } glyph_t;

  typedef enum logic {
    EMIT_IDLE = 1'b0,
    EMIT_PEND = 1'b1
  } emit_state_t;

  function automatic glyph_t seg7_decode(input logic [SEG_W-1:0] seg);
    glyph_t r;
    r.bad   = 1'b0;
    r.value = 4'h0;
    case (seg)
      SEG_0:   r.value = 4'h0;
      SEG_1:   r.value = 4'h1;
      SEG_2:   r.value = 4'h2;
      SEG_3:   r.value = 4'h3;
      SEG_4:   r.value = 4'h4;
      SEG_5:   r.value = 4'h5;
      SEG_6:   r.value = 4'h6;
      SEG_7:   r.value = 4'h7;
      SEG_8:   r.value = 4'h8;
      SEG_9:   r.value = 4'h9;
      SEG_A:   r.value = 4'hA;
      SEG_B:   r.value = 4'hB;
      SEG_C:   r.value = 4'hC;
      SEG_D:   r.value = 4'hD;
      SEG_E:   r.value = 4'hE;
      SEG_F:   r.value = 4'hF;
      default: r.bad   = 1'b1;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/seg7_glyph_decode.sv
// Combinational glyph decoder: 7-bit segment pattern to {bad, hex nibble}.
// Zero latency; no flow control.
module seg7_glyph_decode
  import seg7_pkg::*;
(
  input  logic [6:0] seg,
  output logic       bad,
  output logic [3:0] value
);

  glyph_t dec;

  assign dec   = seg7_decode(seg);
  assign bad   = dec.bad;
  assign value = dec.value;

endmodule

// File: rtl/seg7_display_reader.sv
// Reads hex digits back off a multiplexed 7-seg bus; frame valid two edges after the final locking sample.
// Sampling never stalls; a pending frame is held until out_ready, newer frames collapse to the latest.
module seg7_display_reader
  import seg7_pkg::*;
#(
  parameter int N_DIGITS      = 4,
  parameter int STABLE_CYCLES = 8,
  parameter bit ACTIVE_LOW    = 1'b0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [6:0]            seg_in,
  input  logic [N_DIGITS-1:0]   dig_sel,
  input  logic                  sample_en,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [4*N_DIGITS-1:0] out_value,
  output logic [N_DIGITS-1:0]   out_bad,
  output logic                  err_sel
);

  localparam logic [7:0] STABLE_MAX = 8'(STABLE_CYCLES);

  // capture stage
  logic [6:0]          seg_fix;
  logic [N_DIGITS-1:0] sel_fix;
  logic                sel_onehot;
  logic                cap_vld;
  logic [6:0]          cap_seg;
  logic [N_DIGITS-1:0] cap_sel;

  assign seg_fix    = ACTIVE_LOW ? ~seg_in  : seg_in;
  assign sel_fix    = ACTIVE_LOW ? ~dig_sel : dig_sel;
  assign sel_onehot = $onehot(sel_fix);

  always_ff @(posedge clk) begin
    if (reset) begin
      cap_vld <= 1'b0;
      cap_seg <= '0;
      cap_sel <= '0;
      err_sel <= 1'b0;
    end else begin
      cap_vld <= sample_en && sel_onehot;
      err_sel <= sample_en && !sel_onehot;
      if (sample_en) begin
        cap_seg <= seg_fix;
        cap_sel <= sel_fix;
      end
    end
  end

  // tracking stage
  logic                  dec_bad;
  logic [3:0]            dec_value;
  logic [6:0]            cand    [N_DIGITS];
  logic [7:0]            cnt     [N_DIGITS];
  logic [7:0]            cnt_upd [N_DIGITS];
  logic [N_DIGITS-1:0]   match;
  logic [N_DIGITS-1:0]   locked;
  logic [4*N_DIGITS-1:0] com_val;
  logic [N_DIGITS-1:0]   com_bad;

  // The captured pattern is the new candidate on both branches, so one decoder serves all digits.
  seg7_glyph_decode u_dec (
    .seg   (cap_seg),
    .bad   (dec_bad),
    .value (dec_value)
  );

  always_comb begin
    for (int k = 0; k < N_DIGITS; k++) begin
      match[k]   = (cap_seg == cand[k]);
      cnt_upd[k] = 8'd1;
      if (match[k]) begin
        cnt_upd[k] = (cnt[k] == STABLE_MAX) ? cnt[k] : cnt[k] + 8'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int k = 0; k < N_DIGITS; k++) begin
        cand[k] <= '0;
        cnt[k]  <= '0;
      end
      locked  <= '0;
      com_val <= '0;
      com_bad <= '0;
    end else if (cap_vld) begin
      for (int k = 0; k < N_DIGITS; k++) begin
        if (cap_sel[k]) begin
          cand[k] <= cap_seg;
          cnt[k]  <= cnt_upd[k];
          // A fresh pattern with STABLE_CYCLES=1 locks immediately, so the lock test wins over the clear.
          if (cnt_upd[k] == STABLE_MAX) begin
            locked[k]          <= 1'b1;
            com_val[4*k +: 4]  <= dec_value;
            com_bad[k]         <= dec_bad;
          end else if (!match[k]) begin
            locked[k] <= 1'b0;
          end
        end
      end
    end
  end

  // emit / handshake; out_value doubles as the record of the last emitted frame
  emit_state_t state;
  emit_state_t state_nxt;
  logic        emitted;
  logic        frame_new;
  logic        load;

  assign frame_new = !emitted || (com_val != out_value) || (com_bad != out_bad);
  assign out_valid = (state == EMIT_PEND);

  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    case (state)
      EMIT_IDLE: begin
        if ((&locked) && frame_new) begin
          state_nxt = EMIT_PEND;
          load      = 1'b1;
        end
      end
      EMIT_PEND: begin
        if (out_ready) begin
          state_nxt = EMIT_IDLE;
        end
      end
      default: state_nxt = EMIT_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= EMIT_IDLE;
      emitted   <= 1'b0;
      out_value <= '0;
      out_bad   <= '0;
    end else begin
      state <= state_nxt;
      if (load) begin
        emitted   <= 1'b1;
        out_value <= com_val;
        out_bad   <= com_bad;
      end
    end
  end

endmodule

// File: tb/tb_seg7_display_reader.sv
// Bench for seg7_display_reader: frame table, directed corner sequences, and a randomized
// run compared every cycle against a run-length reference model.
module tb_seg7_display_reader;

  localparam int N = 4;
  localparam int S = 8;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [6:0]  seg_in = '0;
  logic [3:0]  dig_sel = '0;
  logic        sample_en = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [15:0] out_value;
  logic [3:0]  out_bad;
  logic        err_sel;

  always #5 clk = ~clk;

  seg7_display_reader #(
    .N_DIGITS      (N),
    .STABLE_CYCLES (S),
    .ACTIVE_LOW    (1'b0)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .seg_in    (seg_in),
    .dig_sel   (dig_sel),
    .sample_en (sample_en),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_value (out_value),
    .out_bad   (out_bad),
    .err_sel   (err_sel)
  );

  logic [6:0] glyph [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                             7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

  function automatic logic [4:0] ref_decode(input logic [6:0] p);
    for (int i = 0; i < 16; i++) begin
      if (glyph[i] == p) return {1'b0, 4'(i)};
    end
    return 5'b1_0000;
  endfunction

  // Reference model: a digit is locked when its last S samples are identical.
  logic [6:0]  hist [N][$];
  logic [N-1:0] m_locked = '0;
  logic [15:0] m_cval = '0;
  logic [3:0]  m_cbad = '0;
  logic        m_v = 1'b0;
  logic [15:0] m_val = '0;
  logic [3:0]  m_bad = '0;
  logic        m_emit = 1'b0;
  logic        m_err = 1'b0;
  logic        pc_vld = 1'b0;
  logic [6:0]  pc_pat = '0;
  int          pc_dig = 0;

  function automatic logic run_ok(input int k);
    if (hist[k].size() < S) return 1'b0;
    for (int i = 0; i < hist[k].size(); i++) begin
      if (hist[k][i] != hist[k][hist[k].size()-1]) return 1'b0;
    end
    return 1'b1;
  endfunction

  always @(posedge clk) begin
    logic [4:0] d;
    if (reset) begin
      for (int k = 0; k < N; k++) hist[k].delete();
      m_locked = '0; m_cval = '0; m_cbad = '0;
      m_v = 1'b0; m_val = '0; m_bad = '0; m_emit = 1'b0;
      m_err = 1'b0; pc_vld = 1'b0;
    end else begin
      if (m_v) begin
        if (out_ready) m_v = 1'b0;
      end else if ((&m_locked) && (!m_emit || m_cval != m_val || m_cbad != m_bad)) begin
        m_v = 1'b1; m_val = m_cval; m_bad = m_cbad; m_emit = 1'b1;
      end
      if (pc_vld) begin
        hist[pc_dig].push_back(pc_pat);
        if (hist[pc_dig].size() > S) void'(hist[pc_dig].pop_front());
        m_locked[pc_dig] = run_ok(pc_dig);
        if (m_locked[pc_dig]) begin
          d = ref_decode(pc_pat);
          m_cval[4*pc_dig +: 4] = d[3:0];
          m_cbad[pc_dig] = d[4];
        end
      end
      pc_vld = sample_en && ($countones(dig_sel) == 1);
      m_err  = sample_en && ($countones(dig_sel) != 1);
      pc_pat = seg_in;
      for (int k = 0; k < N; k++) if (dig_sel[k]) pc_dig = k;
    end
  end

  int n_cmp = 0;
  int n_bad = 0;
  int vld_pulses = 0;
  int err_pulses = 0;
  logic prev_v = 1'b0;
  logic [15:0] got_val = '0;
  logic [3:0]  got_bad = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic tick(input logic en, input logic [3:0] sel, input logic [6:0] seg);
    sample_en = en; dig_sel = sel; seg_in = seg;
    @(negedge clk);
    n_cmp++;
    if ({out_valid, out_value, out_bad, err_sel} !== {m_v, m_val, m_bad, m_err}) begin
      n_bad++;
      if (n_bad <= 20)
        $display("FAIL model t=%0t: dut v=%b val=%h bad=%b err=%b, ref v=%b val=%h bad=%b err=%b",
                 $time, out_valid, out_value, out_bad, err_sel, m_v, m_val, m_bad, m_err);
    end
    if (out_valid && !prev_v) begin
      vld_pulses++; got_val = out_value; got_bad = out_bad;
    end
    if (err_sel) err_pulses++;
    prev_v = out_valid;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick(1'b0, 4'b0000, 7'h00);
  endtask

  task automatic pass(input logic [3:0][6:0] pats);
    for (int k = 0; k < N; k++) tick(1'b1, 4'(1 << k), pats[k]);
  endtask

  task automatic passes(input int n, input logic [3:0][6:0] pats);
    for (int i = 0; i < n; i++) pass(pats);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    idle(1);
    reset = 1'b0;
    vld_pulses = 0; err_pulses = 0;
  endtask

  typedef struct {
    logic [3:0][6:0] segs;
    logic [15:0]     val;
    logic [3:0]      bad;
  } vec_t;

  function automatic vec_t mk(input logic [6:0] d0, input logic [6:0] d1, input logic [6:0] d2,
                              input logic [6:0] d3, input logic [15:0] v, input logic [3:0] b);
    vec_t r;
    r.segs = {d3, d2, d1, d0};
    r.val  = v;
    r.bad  = b;
    return r;
  endfunction

  vec_t tbl [6];
  logic [3:0][6:0] base;
  logic [3:0][6:0] alt;
  logic [3:0][6:0] disp;

  initial begin
    tbl[0] = mk(7'h3F, 7'h06, 7'h5B, 7'h4F, 16'h3210, 4'b0000);
    tbl[1] = mk(7'h3F, 7'h00, 7'h5B, 7'h4F, 16'h3200, 4'b0010);
    tbl[2] = mk(7'h77, 7'h7C, 7'h39, 7'h5E, 16'hDCBA, 4'b0000);
    tbl[3] = mk(7'h79, 7'h71, 7'h7F, 7'h6F, 16'h98FE, 4'b0000);
    tbl[4] = mk(7'h66, 7'h6D, 7'h7D, 7'h07, 16'h7654, 4'b0000);
    tbl[5] = mk(7'h01, 7'h40, 7'h3F, 7'h06, 16'h1000, 4'b0011);
    base = {7'h4F, 7'h5B, 7'h06, 7'h3F};

    // reset state
    do_reset();
    check("reset out_valid", 32'(out_valid), 32'd0);
    check("reset out_value", 32'(out_value), 32'd0);
    check("reset out_bad",   32'(out_bad),   32'd0);
    check("reset err_sel",   32'(err_sel),   32'd0);

    // frame table
    out_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      do_reset();
      passes(S, tbl[i].segs);
      idle(4);
      check($sformatf("table%0d pulses", i), 32'(vld_pulses), 32'd1);
      check($sformatf("table%0d value", i),  32'(got_val), 32'(tbl[i].val));
      check($sformatf("table%0d bad", i),    32'(got_bad), 32'(tbl[i].bad));
    end

    // glitch on digit 2 during pass 5
    do_reset();
    alt = base; alt[2] = 7'h7F;
    passes(4, base);
    pass(alt);
    passes(7, base);
    idle(4);
    check("glitch early pulses", 32'(vld_pulses), 32'd0);
    pass(base);
    idle(4);
    check("glitch pulses", 32'(vld_pulses), 32'd1);
    check("glitch value",  32'(got_val), 32'h3210);

    // backpressure: frame frozen, newest frame follows one cycle after transfer
    out_ready = 1'b0;
    do_reset();
    passes(S, base);
    idle(4);
    check("bp first valid", 32'(out_valid), 32'd1);
    alt = base; alt[0] = 7'h77;
    passes(S, alt);
    idle(4);
    check("bp held valid", 32'(out_valid), 32'd1);
    check("bp held value", 32'(out_value), 32'h3210);
    out_ready = 1'b1;
    idle(1);
    check("bp gap valid", 32'(out_valid), 32'd0);
    idle(1);
    check("bp next valid", 32'(out_valid), 32'd1);
    check("bp next value", 32'(out_value), 32'h321A);
    idle(3);
    check("bp pulses", 32'(vld_pulses), 32'd2);

    // select errors leave the per-digit counts alone
    do_reset();
    passes(S-1, base);
    idle(3);
    check("sel early pulses", 32'(vld_pulses), 32'd0);
    tick(1'b1, 4'b0110, 7'h3F);
    tick(1'b1, 4'b0000, 7'h3F);
    idle(2);
    check("sel err pulses", 32'(err_pulses), 32'd2);
    pass(base);
    idle(4);
    check("sel pulses", 32'(vld_pulses), 32'd1);
    check("sel value",  32'(got_val), 32'h3210);

    // reset while a frame is pending
    out_ready = 1'b0;
    do_reset();
    passes(S, base);
    idle(3);
    check("mid valid before reset", 32'(out_valid), 32'd1);
    do_reset();
    check("mid reset valid", 32'(out_valid), 32'd0);
    check("mid reset value", 32'(out_value), 32'd0);
    check("mid reset bad",   32'(out_bad),   32'd0);
    out_ready = 1'b1;
    passes(S-1, base);
    idle(4);
    check("mid relock early", 32'(vld_pulses), 32'd0);
    pass(base);
    idle(4);
    check("mid relock pulses", 32'(vld_pulses), 32'd1);
    check("mid relock value",  32'(got_val), 32'h3210);

    // randomized run against the reference model
    do_reset();
    for (int k = 0; k < N; k++) disp[k] = glyph[$urandom_range(0, 15)];
    for (int c = 0; c < 4000; c++) begin
      int rr;
      logic [3:0] sel;
      if ($urandom_range(0, 59) == 0) begin
        rr = $urandom_range(0, N-1);
        disp[rr] = ($urandom_range(0, 3) != 0) ? glyph[$urandom_range(0, 15)] : 7'($urandom);
      end
      out_ready = ($urandom_range(0, 3) != 0);
      reset = ($urandom_range(0, 699) == 0);
      rr = c % N;
      sel = ($urandom_range(0, 9) != 0) ? 4'(1 << rr) : 4'($urandom);
      tick(($urandom_range(0, 4) != 0),
           sel,
           ($urandom_range(0, 49) == 0) ? 7'($urandom) : disp[rr]);
    end
    reset = 1'b0;
    idle(4);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/seg7_display_reader.md
# seg7_display_reader

Recovers hex digits from a multiplexed seven-segment bus: the inverse of the segment-drive decoders. Samples the segment pattern and one-hot digit select, waits for each digit's glyph to be stable for a set number of samples, and maps glyphs back to 4-bit hex values. Each changed, fully locked frame is delivered over a valid/ready handshake. Used wherever the design must read back or verify the value shown on a display.

## Interface
- N_DIGITS, 4: number of multiplexed digits.
- STABLE_CYCLES, 8: identical consecutive samples of a digit needed to lock it. Range 1..255.
- ACTIVE_LOW, 0: when 1, `seg_in` and `dig_sel` are inverted before use.
- clk  in  1  sole clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- seg_in  in  7  segment pattern; bit0=a … bit6=g.
- dig_sel  in  N_DIGITS  one-hot digit select; bit k = digit k (digit 0 = least significant nibble).
- sample_en  in  1  sample strobe for `seg_in` and `dig_sel`.
- out_valid  out  1  frame available.
- out_ready  in  1  consumer accepts the frame.
- out_value  out  4*N_DIGITS  digit k in bits [4k+3:4k].
- out_bad  out  N_DIGITS  bit k set when digit k's glyph is not a legal hex glyph; that nibble is 0.
- err_sel  out  1  one-cycle pulse when a sampled `dig_sel` was not one-hot.

## Operation
- Legal glyphs (hex pattern g..a), one per hex digit:
  - 0=3F 1=06 2=5B 3=4F 4=66 5=6D 6=7D 7=07
  - 8=7F 9=6F A=77 b=7C C=39 d=5E E=79 F=71
  - Every other pattern, including 00 (blank), decodes as bad with value 0.
- Stage 1 (capture): when `sample_en`=1, register `seg_in` and `dig_sel` after polarity correction.
  - If `dig_sel` is zero or multi-hot, discard the sample and pulse `err_sel` on the next cycle.
- Stage 2 (track), per digit k selected by the captured sample:
  - Raw pattern equal to cand[k]: cnt[k] increments, saturating at STABLE_CYCLES.
  - Otherwise: cand[k] takes the new pattern, cnt[k] becomes 1, and locked[k] clears.
  - When cnt[k] reaches STABLE_CYCLES: locked[k] sets and committed[k] takes {bad, value} of cand[k], on the same edge.
- Stability is judged on the raw 7-bit pattern, not on the decoded value.
- Emit rule: `out_valid` sets when all of the following hold:
  - all locked[] are 1;
  - no frame is pending;
  - the committed frame differs from the last emitted frame, or no frame has been emitted since reset.
- When `out_valid` sets, `out_value` and `out_bad` are loaded from committed[].
- Handshake:
  - While `out_valid`=1 and `out_ready`=0, `out_value` and `out_bad` are frozen.
  - Transfer completes on a cycle with `out_valid` and `out_ready` both 1. `out_valid` clears on the next edge.
  - If the committed frame changed while the frame was pending, `out_valid` re-asserts one cycle later with the newest frame. Intermediate frames are dropped.
- A digit that is never sampled never locks, so no frame is emitted.

## Timing
- Reset values:
  - `out_valid`=0, `out_value`=0, `out_bad`=0, `err_sel`=0.
  - All cand, cnt, locked and committed cleared; the "emitted since reset" flag cleared.
- Latency: the final qualifying `sample_en` is sampled at edge E0. cnt and locked update at E1. `out_valid` is high after E2 when all other digits are already locked.
- With STABLE_CYCLES=1, a single sample locks a digit.
- Simultaneous handshake and commit: transfer of the old frame completes; the new frame follows per the re-assert rule.
- Reset mid-transfer: a pending frame is lost. The next frame after reset requires full re-lock of every digit.
- `sample_en` may be asserted every cycle; there is no backpressure on sampling.

## Structure
- Package `seg7_pkg`:
  - the 16 glyph constants SEG_0..SEG_F;
  - `SEG_W`=7;
  - a decode function returning {bad, value[3:0]}.
- Sub-module `seg7_glyph_decode`: combinational 7-bit → {bad, 4-bit} mapping built on the package function, instantiated once in stage 2.
- The top level holds the capture register, per-digit tracking arrays, and the emit/handshake logic.

## Test plan
- **Lock and emit:** N_DIGITS=4, STABLE_CYCLES=8. Drive glyphs 3F,06,5B,4F round-robin on digits 0..3, 8 passes with `out_ready`=1 → exactly one `out_valid` pulse, `out_value`=0x3210, `out_bad`=0.
- **Glitch rejection:** as above, but digit 2 shows 7F on pass 5 only → digit 2 does not lock until 8 further consecutive 5B samples; no frame contains 8.
- **Bad glyph:** digit 1 shows 00 for 8 passes, other digits as in lock-and-emit → `out_value`=0x3200, `out_bad`=4'b0010.
- **Backpressure:** hold `out_ready`=0, then change digit 0 to 77 and let it lock → the first frame stays 0x3210 until `out_ready`=1. The next frame is 0x321A, re-asserted one cycle after the transfer.
- **Select errors:** `sample_en` with `dig_sel`=4'b0110, then 4'b0000 → two `err_sel` pulses; cnt[] unchanged.
- **Mid-transfer reset:** reset while `out_valid`=1 → all outputs 0 on the next edge. The same display then re-emits only after 8 fresh passes.
